game_flow_ctrl: RTL
===================

# game_flow_ctrl

Sequential game-flow controller that consumes the per-cycle `collide`, `reset_req` and `level_complete` flags from the game-state check logic and advances the game through title, play, death, respawn, level-clear and win phases. It sits between the collision/keyboard checks and the motion and level-ROM logic. It issues one-cycle `respawn` and `load_level` strobes, a `freeze` hold for sprite motion, and the current level index. All timed phases are counted in video frames, derived from `vsync`.

## Interface
- `NUM_LEVELS`, 4: number of levels; index 0..NUM_LEVELS-1.
- `LEVEL_W`, 2: width of `level`; must satisfy 2**LEVEL_W >= NUM_LEVELS.
- `DEATH_FRAMES`, 30: frames spent in death phase.
- `DONE_FRAMES`, 60: frames spent in level-clear phase.
- `Clk` in 1: system clock; the only clock.
- `Reset` in 1: asynchronous, active-high reset.
- `vsync` in 1: raw VGA vsync level, synchronous to `Clk`.
- `start` in 1: start key level; the rising edge is used.
- `collide` in 1: man hit spike or apple.
- `reset_req` in 1: player restart key (R).
- `level_complete` in 1: man reached the exit.
- `state` out 3: current `game_state_t`.
- `level` out LEVEL_W: current level index.
- `load_level` out 1: one-cycle strobe; reload level geometry for `level`.
- `respawn` out 1: one-cycle strobe; move man to spawn point.
- `freeze` out 1: hold all sprite motion.
- `death_count` out 10: deaths since game start (see Configuration).

## Operation
- Frame strobe `fs`: asserted one `Clk` after a rising edge of `vsync`, where the edge is detected against a registered copy. `fs` is high for exactly one cycle.
- Start edge: `start & ~start_q`.
- States and transitions:
  - IDLE: the reset state. On a start edge: `level`←0, death counter←0, go to LOAD.
  - LOAD: lasts 1 cycle. `load_level`=1 and `respawn`=1. Go to PLAY.
  - PLAY: transitions are evaluated every `Clk`, with priority `reset_req` > `collide` > `level_complete`.
    - `reset_req` → RESPAWN. No death is counted.
    - `collide` → DYING. Death counter +1.
    - `level_complete` → LVLDONE.
  - DYING: `freeze`=1. The frame counter is loaded with DEATH_FRAMES on entry and decremented on each `fs`. When it reaches 0, go to RESPAWN.
  - RESPAWN: lasts 1 cycle. `respawn`=1. Go to PLAY.
  - LVLDONE: `freeze`=1. The frame counter is loaded with DONE_FRAMES and decremented on `fs`. When it reaches 0:
    - if `level`==NUM_LEVELS-1, go to WIN;
    - else `level`+1 and go to LOAD.
  - WIN: `freeze`=1. On a start edge, behave exactly as a start edge in IDLE.
- All inputs are ignored outside PLAY, except `start` in IDLE and WIN.
- `freeze`=1 in IDLE, LOAD, DYING, RESPAWN, LVLDONE and WIN. `freeze`=0 only in PLAY.
- Frame counter width is $clog2(max(DEATH_FRAMES,DONE_FRAMES)+1).
- A count of 0 in DYING or LVLDONE exits on the first `fs`.
- `level` never wraps; it holds at NUM_LEVELS-1.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=IDLE, `level`=0, `death_count`=0.
  - `load_level`=0, `respawn`=0, `freeze`=1.
  - Internal `vsync` and `start` edge registers = 0.
- An input flag asserted in PLAY at cycle N produces the new `state` at N+1.
- Strobes are high for the single cycle that the state is LOAD or RESPAWN.
- DYING lasts DEATH_FRAMES `fs` pulses plus up to one frame of phase; the exit cycle is the cycle after the last `fs`.
- `Reset` asserted mid-phase returns to IDLE immediately and asynchronously. No strobe is emitted.

## Configuration
- `GAME_DEATH_COUNTER_EN`:
  - Defined: `death_count` increments on each PLAY→DYING transition and saturates at 1023.
  - Undefined: no counter register is built and `death_count` is tied to 0.
- The state machine is identical with and without the macro.

## Structure
- Package `game_pkg` holds:
  - `typedef enum logic [2:0] game_state_t` with encodings IDLE=0, LOAD=1, PLAY=2, DYING=3, RESPAWN=4, LVLDONE=5, WIN=6.
  - The saturation constant DEATH_MAX=1023.
- One sub-module, `frame_timer`, which contains:
  - the `vsync` edge detector producing `fs`;
  - a loadable down-counter with inputs `load`, `load_val` and output `zero`.

## Test plan
- Reset with `start`=0 → `state`=0, `freeze`=1. A `start` pulse → one cycle with `load_level`=1 and `respawn`=1, then `state`=2 and `freeze`=0.
- In PLAY, `collide`=1 for 1 cycle → `state`=3, `death_count`=1. After 30 `vsync` edges → one `respawn` pulse, then `state`=2.
- In PLAY, `collide`, `reset_req` and `level_complete` all asserted in the same cycle → RESPAWN and `death_count` unchanged.
- `level_complete` on `level`=3 → LVLDONE for 60 frames → `state`=6. Then a `start` edge → `level`=0, `death_count`=0, `load_level` pulse.
- `Reset` asserted during DYING after 10 frames → `state`=0 immediately. No `respawn` pulse occurs before or after release.
- With `GAME_DEATH_COUNTER_EN` defined, 1030 collisions → `death_count`=1023. With the macro undefined, `death_count`=0 throughout.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, death-counter ceiling and a constant helper
package game_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PLAY    = 3'd2,
        DYING   = 3'd3,
        RESPAWN = 3'd4,
        LVLDONE = 3'd5,
        WIN     = 3'd6
    } game_state_t;
    localparam int DEATH_MAX = 1023;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: check-logic flags in, phase/strobe/level outputs back to motion and level ROM
interface game_flow_ctrl_if
    import game_pkg::*;
#(
    parameter int LEVEL_W = 2
);
    logic               vsync;
    logic               start;
    logic               collide;
    logic               reset_req;
    logic               level_complete;
    game_state_t        state;
    logic [LEVEL_W-1:0] level;
    logic               load_level;
    logic               respawn;
    logic               freeze;
    logic [9:0]         death_count;
    modport master (
        output vsync, start, collide, reset_req, level_complete,
        input  state, level, load_level, respawn, freeze, death_count
    );
    modport slave (
        input  vsync, start, collide, reset_req, level_complete,
        output state, level, load_level, respawn, freeze, death_count
    );
endinterface

// File: rtl/game_flow_ctrl_frame_timer.sv
// frame_timer: vsync rising-edge frame strobe and a loadable frame down-counter
module frame_timer #(
    parameter int W = 6
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         vsync,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic         vsync_q;
    logic         fs;
    logic [W-1:0] cnt;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vsync_q <= 1'b0;
            fs      <= 1'b0;
            cnt     <= '0;
        end else begin
            vsync_q <= vsync;
            fs      <= vsync & ~vsync_q;
            cnt     <= load ? load_val : (fs && cnt != '0) ? cnt - 1'b1 : cnt;
        end
    end
    // high on the frame that takes the count to zero, or on the first frame if already zero
    assign zero = fs && cnt <= W'(1);
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: title/play/death/respawn/level-clear/win sequencer driven by frame-counted phases
// Optional GAME_DEATH_COUNTER_EN builds the saturating death counter; otherwise death_count is 0.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LEVELS   = 4,
    parameter int LEVEL_W      = 2,
    parameter int DEATH_FRAMES = 30,
    parameter int DONE_FRAMES  = 60
) (
    input logic              Clk,
    input logic              Reset,
    game_flow_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(max_int(DEATH_FRAMES, DONE_FRAMES) + 1);
    localparam logic [LEVEL_W-1:0] LAST = LEVEL_W'(NUM_LEVELS - 1);
    game_state_t state, next;
    logic start_q, start_edge, restart, zero;
    logic [CNT_W-1:0] load_val;
    assign start_edge = bus.start & ~start_q;
    assign restart    = (state == IDLE || state == WIN) && start_edge;
    assign load_val   = (bus.level_complete && !bus.collide && !bus.reset_req)
                        ? CNT_W'(DONE_FRAMES) : CNT_W'(DEATH_FRAMES);
    // counter is held loaded throughout PLAY so it starts fresh on entry to DYING/LVLDONE
    frame_timer #(.W(CNT_W)) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .vsync    (bus.vsync),
        .load     (state == PLAY),
        .load_val (load_val),
        .zero     (zero)
    );
    always_comb begin
        next = state;
        case (state)
            IDLE, WIN:     if (start_edge) next = LOAD;
            LOAD, RESPAWN: next = PLAY;
            PLAY:          next = bus.reset_req ? RESPAWN : bus.collide ? DYING
                                : bus.level_complete ? LVLDONE : PLAY;
            DYING:         if (zero) next = RESPAWN;
            LVLDONE:       if (zero) next = (bus.level == LAST) ? WIN : LOAD;
            default:       next = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            start_q        <= 1'b0;
            bus.level      <= '0;
            bus.load_level <= 1'b0;
            bus.respawn    <= 1'b0;
            bus.freeze     <= 1'b1;
        end else begin
            state          <= next;
            start_q        <= bus.start;
            bus.level      <= restart ? '0
                            : (state == LVLDONE && zero && bus.level != LAST) ? bus.level + 1'b1
                            : bus.level;
            bus.load_level <= next == LOAD;
            bus.respawn    <= next == LOAD || next == RESPAWN;
            bus.freeze     <= next != PLAY;
        end
    end
    assign bus.state = state;
`ifdef GAME_DEATH_COUNTER_EN
    logic [9:0] deaths;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) deaths <= '0;
        else if (restart) deaths <= '0;
        else if (state == PLAY && !bus.reset_req && bus.collide && deaths != 10'(DEATH_MAX))
            deaths <= deaths + 1'b1;
    end
    assign bus.death_count = deaths;
`else
    assign bus.death_count = '0;
`endif
endmodule
